// File: rtl/edge_period_capture.sv
// edge_period_capture
//   Samples a free-running counter on each rising edge of an asynchronous
//   event and queues the elapsed count between successive edges (period,
//   modulo 2^WIDTH) in a small show-ahead FIFO with a valid/ready handshake.
//   Periods that arrive while the FIFO is full are dropped. Each drop sets a
//   sticky overflow flag and bumps a saturating drop counter.
//
// Ports
//   clk        single clock, all state on posedge
//   rst_async  asynchronous active-high reset
//   count_in   free-running counter value (clk domain)
//   evt_in     external event (asynchronous to clk)
//   en         capture enable; low disarms the period measurement
//   per_data   period at FIFO head, 0 when empty
//   per_valid  FIFO non-empty
//   per_ready  consumer pops head when per_valid & per_ready
//   ovf        sticky: at least one period dropped
//   drop_cnt   dropped periods, saturates at 255
//   ovf_clr    synchronous clear of ovf and drop_cnt (a same-cycle drop wins)
module edge_period_capture #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_async,
    input  logic [WIDTH-1:0] count_in,
    input  logic             evt_in,
    input  logic             en,
    output logic [WIDTH-1:0] per_data,
    output logic             per_valid,
    input  logic             per_ready,
    output logic             ovf,
    output logic [7:0]       drop_cnt,
    input  logic             ovf_clr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    // Event synchronizer plus one history flop for rising-edge detection.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   sync_out;
    logic                   evt_edge;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign evt_edge = sync_out & ~hist_q;

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], evt_in};
            hist_q <= sync_out;
        end
    end

    // Period measurement. The first qualified edge after reset or after a
    // disable only primes last_ts; later edges produce a period.
    logic             armed_q;
    logic [WIDTH-1:0] last_ts_q;
    logic             cap;
    logic [WIDTH-1:0] period;

    assign cap    = evt_edge & en;
    assign period = count_in - last_ts_q;

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            armed_q   <= 1'b0;
            last_ts_q <= '0;
        end else begin
            if (cap)
                last_ts_q <= count_in;
            if (!en)
                armed_q <= 1'b0;
            else if (evt_edge)
                armed_q <= 1'b1;
        end
    end

    // FIFO
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             full, push_req, push_ok, pop, drop;

    assign full      = (cnt_q == CW'(DEPTH));
    assign per_valid = (cnt_q != '0);
    assign per_data  = per_valid ? mem[rd_ptr_q] : '0;
    assign pop       = per_valid & per_ready;
    assign push_req  = cap & armed_q;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok   = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_q] <= period;
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Overflow bookkeeping; a drop in the clear cycle restarts the count at 1.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (ovf_clr)
                drop_cnt <= 8'd1;
            else if (drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end else if (ovf_clr) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_edge_period_capture.sv
module tb_edge_period_capture;

    logic        clk = 1'b0;
    logic        rst_async = 1'b1;
    logic [15:0] count_in = '0;
    logic        evt_in = 1'b0;
    logic        en = 1'b1;
    logic [15:0] per_data;
    logic        per_valid;
    logic        per_ready = 1'b0;
    logic        ovf;
    logic [7:0]  drop_cnt;
    logic        ovf_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    edge_period_capture #(.WIDTH(16), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_async (rst_async),
        .count_in  (count_in),
        .evt_in    (evt_in),
        .en        (en),
        .per_data  (per_data),
        .per_valid (per_valid),
        .per_ready (per_ready),
        .ovf       (ovf),
        .drop_cnt  (drop_cnt),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cnt;
        logic        exp_v;
        logic [15:0] exp_d;
        logic        exp_ovf;
        logic [7:0]  exp_drop;
    } vec_t;

    vec_t tbl [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_async = 1'b1;
        evt_in = 1'b0;
        per_ready = 1'b0;
        ovf_clr = 1'b0;
        en = 1'b1;
        step();
        step();
        rst_async = 1'b0;
        step();
    endtask

    // One event pulse with count_in held at c; rdy/clr are applied only in
    // the cycle whose closing edge performs the capture.
    task automatic fire_x(input logic [15:0] c, input logic rdy, input logic clr);
        count_in = c;
        evt_in = 1'b1;
        step();
        evt_in = 1'b0;
        step();
        per_ready = rdy;
        ovf_clr = clr;
        step();
        per_ready = 1'b0;
        ovf_clr = 1'b0;
        step();
    endtask

    task automatic fire(input logic [15:0] c);
        fire_x(c, 1'b0, 1'b0);
    endtask

    task automatic drain_one(input string name, input int exp);
        check({name, "_valid"}, int'(per_valid), 1);
        check(name, int'(per_data), exp);
        per_ready = 1'b1;
        step();
        per_ready = 1'b0;
    endtask

    initial begin
        tbl[0] = '{16'd0,   1'b0, 16'd0,  1'b0, 8'd0};
        tbl[1] = '{16'd10,  1'b1, 16'd10, 1'b0, 8'd0};
        tbl[2] = '{16'd30,  1'b1, 16'd10, 1'b0, 8'd0};
        tbl[3] = '{16'd60,  1'b1, 16'd10, 1'b0, 8'd0};
        tbl[4] = '{16'd100, 1'b1, 16'd10, 1'b0, 8'd0};
        tbl[5] = '{16'd150, 1'b1, 16'd10, 1'b1, 8'd1};
        tbl[6] = '{16'd210, 1'b1, 16'd10, 1'b1, 8'd2};

        // Reset state
        rst_async = 1'b1;
        step();
        check("rst_valid", int'(per_valid), 0);
        check("rst_data", int'(per_data), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_drop", int'(drop_cnt), 0);
        do_reset();

        // Basic period with exact latency
        fire(16'd100);
        check("prime_valid", int'(per_valid), 0);
        count_in = 16'd350;
        evt_in = 1'b1;
        step();
        evt_in = 1'b0;
        step();
        check("lat_early_valid", int'(per_valid), 0);
        step();
        check("lat_valid", int'(per_valid), 1);
        check("lat_data", int'(per_data), 250);
        step();
        drain_one("basic_pop", 250);
        check("basic_empty", int'(per_valid), 0);

        // Counter wrap, then a zero period
        do_reset();
        fire(16'hFFF0);
        fire(16'h0010);
        drain_one("wrap", 16'h0020);
        fire(16'h0010);
        drain_one("zero_period", 0);

        // Fill / overflow from the table
        do_reset();
        for (int i = 0; i < 7; i++) begin
            fire(tbl[i].cnt);
            check($sformatf("tbl%0d_valid", i), int'(per_valid), int'(tbl[i].exp_v));
            check($sformatf("tbl%0d_data", i), int'(per_data), int'(tbl[i].exp_d));
            check($sformatf("tbl%0d_ovf", i), int'(ovf), int'(tbl[i].exp_ovf));
            check($sformatf("tbl%0d_drop", i), int'(drop_cnt), int'(tbl[i].exp_drop));
        end
        for (int i = 0; i < 4; i++)
            drain_one($sformatf("ovf_drain%0d", i), (i + 1) * 10);
        check("ovf_drain_empty", int'(per_valid), 0);

        // Push and pop together while full
        do_reset();
        fire(16'd0);
        fire(16'd10);
        fire(16'd30);
        fire(16'd60);
        fire(16'd100);
        fire_x(16'd150, 1'b1, 1'b0);
        check("pp_ovf", int'(ovf), 0);
        check("pp_drop", int'(drop_cnt), 0);
        check("pp_head", int'(per_data), 20);

        // Drops, drop colliding with clear, clear alone
        fire(16'd210);
        check("d1_ovf", int'(ovf), 1);
        check("d1_cnt", int'(drop_cnt), 1);
        fire(16'd280);
        check("d2_cnt", int'(drop_cnt), 2);
        fire_x(16'd360, 1'b0, 1'b1);
        check("dclr_ovf", int'(ovf), 1);
        check("dclr_cnt", int'(drop_cnt), 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("clr_ovf", int'(ovf), 0);
        check("clr_cnt", int'(drop_cnt), 0);
        for (int i = 0; i < 4; i++)
            drain_one($sformatf("pp_drain%0d", i), (i + 2) * 10);
        check("pp_empty", int'(per_valid), 0);

        // Saturation of drop_cnt
        for (int i = 0; i < 4; i++)
            fire(16'(400 + i * 5));
        for (int i = 0; i < 300; i++)
            fire(16'(1000 + i));
        check("sat_cnt", int'(drop_cnt), 255);
        check("sat_ovf", int'(ovf), 1);

        // Enable gating
        do_reset();
        fire(16'd100);
        en = 1'b0;
        fire(16'd200);
        check("en0_a", int'(per_valid), 0);
        fire(16'd300);
        check("en0_b", int'(per_valid), 0);
        en = 1'b1;
        fire(16'd400);
        check("reen_prime", int'(per_valid), 0);
        fire(16'd450);
        check("reen_valid", int'(per_valid), 1);
        check("reen_data", int'(per_data), 50);

        // Reset mid-stream
        do_reset();
        fire(16'd0);
        fire(16'd10);
        fire(16'd20);
        fire(16'd30);
        check("mid_valid", int'(per_valid), 1);
        rst_async = 1'b1;
        #1;
        check("async_valid", int'(per_valid), 0);
        check("async_data", int'(per_data), 0);
        step();
        rst_async = 1'b0;
        step();
        fire(16'd500);
        check("post_rst_prime", int'(per_valid), 0);
        fire(16'd520);
        check("post_rst_data", int'(per_data), 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
